sccb_cfg_sequencer: RTL
=======================

Name: sccb_cfg_sequencer

Overview:
Sequences the SCCB write master for the OV7670. Walks a register ROM of {reg_addr, data} words, with delay and end markers, and issues one 3-byte write per entry. Retries on NACK or timeout, and reports a fault address if retries are exhausted. After init, arbitrates single runtime register writes from game logic (brightness/colour tweaks) onto the same master; init always has priority.

Parameters:
SLAVE_ADDR, 8'h42, SCCB write address prefixed to every transaction
ROM_AW, 8, ROM address width; sequencing stops at address 2**ROM_AW-1 if no end marker is found
GAP_TICKS, 100, idle ticks between consecutive transactions
DELAY_TICKS, 4000, ticks waited on a delay marker (10 ms at 400 kHz)
TIMEOUT_TICKS, 1023, ticks without sccb_done before the attempt counts as failed
MAX_RETRY, 3, retries per entry after the first failed attempt

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
tick  in  1  one-clk enable at the SCCB bit rate; all timing counters decrement only on tick
init_start  in  1  pulse; starts the ROM sequence from address 0
rom_addr  out  ROM_AW  ROM read address
rom_data  in  16  ROM word {reg_addr, data}; valid 1 clk after rom_addr changes
rt_req  in  1  runtime write request; held high until rt_ack
rt_reg_addr  in  8  runtime register address; stable while rt_req is high
rt_data  in  8  runtime write data; stable while rt_req is high
rt_ack  out  1  1-clk pulse when the runtime write completes (success or fail)
rt_fail  out  1  valid with rt_ack; 1 = retries exhausted
sccb_start  out  1  1-clk pulse to the SCCB master
sccb_data  out  24  {SLAVE_ADDR, reg_addr, data}; held stable from sccb_start until completion
sccb_done  in  1  1-clk pulse from the master at end of transaction
sccb_nack  in  1  valid with sccb_done; 1 = slave NACKed
init_busy  out  1  high while the ROM sequence runs
init_done  out  1  sticky; set on clean end of sequence, cleared by init_start
err  out  1  sticky; set when an init entry exhausts its retries, cleared by init_start
err_addr  out  ROM_AW  ROM address of the failing entry; valid while err is high

Behaviour:
- Reset: state IDLE; rom_addr=0; sccb_data=0; all 1-bit outputs 0; retry and timer counts 0.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT_DONE, GAP, DELAY, RT_ISSUE, RT_WAIT.
- IDLE, on init_start (wins over a simultaneous rt_req): rom_addr<=0; init_busy<=1; clear init_done and err; go to FETCH.
- IDLE, on rt_req only: go to RT_ISSUE.
- FETCH: one clk for ROM latency, then DECODE.
- DECODE, on rom_data==16'hFFFF: init_done<=1, init_busy<=0, go to IDLE.
- DECODE, on rom_data==16'hFFF0: load timer with DELAY_TICKS, go to DELAY.
- DECODE, otherwise: go to ISSUE.
- DELAY: when the timer reaches 0, rom_addr++ and go to FETCH.
- ISSUE: sccb_start=1 for exactly 1 clk; latch sccb_data; load timer with TIMEOUT_TICKS; go to WAIT_DONE.
- WAIT_DONE, on sccb_done with sccb_nack=0: retry count<=0; rom_addr++; go to GAP. If rom_addr was already 2**ROM_AW-1, set init_done instead (no wrap) and go to IDLE.
- WAIT_DONE, on sccb_done with sccb_nack=1, or timer reaching 0: this is a failure.
  - If retries < MAX_RETRY: retries++; go to GAP, then re-ISSUE the same entry.
  - Else: err<=1; err_addr<=rom_addr; init_busy<=0; init_done stays 0; go to IDLE.
- GAP: wait GAP_TICKS ticks. Then go to FETCH in init mode, or RT_ISSUE when retrying a runtime write.
- RT_ISSUE / RT_WAIT: same handshake, retry and timeout rules, using {SLAVE_ADDR, rt_reg_addr, rt_data}.
  - Success: rt_ack=1 for 1 clk, rt_fail=0; go to GAP, then IDLE.
  - Exhausted: rt_ack=1, rt_fail=1.
  - err is never set by runtime writes.
- rt_req asserted during init is held off; it is served in the first IDLE after init ends.
- init_start outside IDLE is ignored.
- sccb_done outside WAIT_DONE/RT_WAIT is ignored.
- sccb_done and timer expiry in the same clk: sccb_done takes precedence.
- Timer decrements only on cycles where tick=1; sccb_done is sampled every clk.
- Asynchronous reset mid-transaction returns everything to reset values within the same cycle; no further sccb_start is issued.

Decomposition:
- Package sccb_pkg holds:
  - state enum sccb_seq_state_e;
  - constants SCCB_ROM_END=16'hFFFF, SCCB_ROM_DELAY=16'hFFF0, OV7670_WR_ADDR=8'h42;
  - typedef sccb_word_t (24-bit).
- Sub-module sccb_tick_timer: loadable 16-bit down-counter with load, tick enable and zero flag. It is shared by the GAP, DELAY and TIMEOUT paths.

Test Plan:
- ROM {12_80, FFF0, 12_14, FFFF}, slave always ACKs, init_start pulse -> exactly 2 sccb_start with sccb_data 0x421280 then 0x421214; gap of at least DELAY_TICKS ticks between them; init_done=1, err=0.
- Entry 3 NACKed on every attempt -> 1+MAX_RETRY=4 starts with identical sccb_data; then err=1, err_addr=3, init_done=0, init_busy=0.
- Slave never returns sccb_done -> each attempt ends after TIMEOUT_TICKS ticks; 4 attempts, then err=1.
- rt_req with reg 0x55, data 0x10 raised mid-init -> no runtime transaction until init_done; then sccb_data=0x425510, rt_ack pulse with rt_fail=0.
- init_start and rt_req in the same clk from IDLE -> ROM sequence runs first; runtime write follows it.
- reset_n low during WAIT_DONE -> all outputs 0 immediately; after release, no sccb_start until the next init_start or rt_req.

Source files
------------

// File: rtl/sccb_pkg.sv
// Shared types and constants for the OV7670 SCCB configuration sequencer.
package sccb_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        ISSUE,
        WAIT_DONE,
        GAP,
        DELAY,
        RT_ISSUE,
        RT_WAIT
    } sccb_seq_state_e;

    localparam logic [15:0] SCCB_ROM_END   = 16'hFFFF;
    localparam logic [15:0] SCCB_ROM_DELAY = 16'hFFF0;
    localparam logic [7:0]  OV7670_WR_ADDR = 8'h42;

    typedef logic [23:0] sccb_word_t;

    // Builds the 3-byte write phase {device, register, data}.
    function automatic sccb_word_t sccb_make_word(input logic [7:0] dev,
                                                  input logic [7:0] reg_addr,
                                                  input logic [7:0] data);
        return {dev, reg_addr, data};
    endfunction

endpackage

// File: rtl/sccb_tick_timer.sv
// Loadable 16-bit down-counter advanced by the SCCB bit-rate tick.
// One instance serves the inter-transaction gap, the delay marker and the
// per-attempt timeout, since only one of them is ever running.
module sccb_tick_timer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic        zero
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Load wins over counting; the counter parks at zero instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (tick && (cnt_q != 16'd0)) begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == 16'd0);

endmodule

// File: rtl/sccb_cfg_sequencer.sv
// Walks the OV7670 register ROM and drives one SCCB write per entry, with
// retry/timeout handling, then arbitrates runtime single-register writes
// onto the same master. The ROM sequence always has priority.
module sccb_cfg_sequencer
    import sccb_pkg::*;
#(
    parameter logic [7:0] SLAVE_ADDR    = OV7670_WR_ADDR,
    parameter int         ROM_AW        = 8,
    parameter int         GAP_TICKS     = 100,
    parameter int         DELAY_TICKS   = 4000,
    parameter int         TIMEOUT_TICKS = 1023,
    parameter int         MAX_RETRY     = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tick,
    input  logic              init_start,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    input  logic              rt_req,
    input  logic [7:0]        rt_reg_addr,
    input  logic [7:0]        rt_data,
    output logic              rt_ack,
    output logic              rt_fail,
    output logic              sccb_start,
    output logic [23:0]       sccb_data,
    input  logic              sccb_done,
    input  logic              sccb_nack,
    output logic              init_busy,
    output logic              init_done,
    output logic              err,
    output logic [ROM_AW-1:0] err_addr
);

    localparam logic [15:0]       GAP_LD     = 16'(GAP_TICKS);
    localparam logic [15:0]       DELAY_LD   = 16'(DELAY_TICKS);
    localparam logic [15:0]       TIMEOUT_LD = 16'(TIMEOUT_TICKS);
    localparam logic [7:0]        RETRY_MAX  = 8'(MAX_RETRY);
    localparam logic [ROM_AW-1:0] ROM_LAST   = '1;
    localparam logic [ROM_AW-1:0] ROM_ONE    = ROM_AW'(1);

    sccb_seq_state_e   state_q,     state_d;
    logic [ROM_AW-1:0] rom_addr_q,  rom_addr_d;
    logic [ROM_AW-1:0] err_addr_q,  err_addr_d;
    sccb_word_t        sccb_data_q, sccb_data_d;
    logic [7:0]        retry_q,     retry_d;
    logic              rt_mode_q,   rt_mode_d;
    logic              init_busy_q, init_busy_d;
    logic              init_done_q, init_done_d;
    logic              err_q,       err_d;
    logic              start_q,     start_d;
    logic              rt_ack_q,    rt_ack_d;
    logic              rt_fail_q,   rt_fail_d;

    logic              tmr_load;
    logic [15:0]       tmr_val;
    logic              tmr_zero;

    sccb_tick_timer u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .tick     (tick),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Next-state and output decode. rt_mode remembers whether the current
    // transaction came from the runtime port so GAP knows where to return.
    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        err_addr_d  = err_addr_q;
        sccb_data_d = sccb_data_q;
        retry_d     = retry_q;
        rt_mode_d   = rt_mode_q;
        init_busy_d = init_busy_q;
        init_done_d = init_done_q;
        err_d       = err_q;
        start_d     = 1'b0;
        rt_ack_d    = 1'b0;
        rt_fail_d   = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = 16'd0;

        case (state_q)
            IDLE: begin
                if (init_start) begin
                    rom_addr_d  = '0;
                    init_busy_d = 1'b1;
                    init_done_d = 1'b0;
                    err_d       = 1'b0;
                    rt_mode_d   = 1'b0;
                    retry_d     = 8'd0;
                    state_d     = FETCH;
                end else if (rt_req) begin
                    rt_mode_d = 1'b1;
                    retry_d   = 8'd0;
                    state_d   = RT_ISSUE;
                end
            end

            FETCH: state_d = DECODE;

            DECODE: begin
                if (rom_data == SCCB_ROM_END) begin
                    init_done_d = 1'b1;
                    init_busy_d = 1'b0;
                    state_d     = IDLE;
                end else if (rom_data == SCCB_ROM_DELAY) begin
                    tmr_load = 1'b1;
                    tmr_val  = DELAY_LD;
                    state_d  = DELAY;
                end else begin
                    state_d = ISSUE;
                end
            end

            DELAY: begin
                if (tmr_zero) begin
                    rom_addr_d = rom_addr_q + ROM_ONE;
                    state_d    = FETCH;
                end
            end

            ISSUE: begin
                start_d     = 1'b1;
                sccb_data_d = sccb_make_word(SLAVE_ADDR, rom_data[15:8], rom_data[7:0]);
                tmr_load    = 1'b1;
                tmr_val     = TIMEOUT_LD;
                state_d     = WAIT_DONE;
            end

            WAIT_DONE: begin
                if (sccb_done && !sccb_nack) begin
                    retry_d = 8'd0;
                    if (rom_addr_q == ROM_LAST) begin
                        init_done_d = 1'b1;
                        init_busy_d = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        rom_addr_d = rom_addr_q + ROM_ONE;
                        tmr_load   = 1'b1;
                        tmr_val    = GAP_LD;
                        state_d    = GAP;
                    end
                end else if (sccb_done || tmr_zero) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d  = retry_q + 8'd1;
                        tmr_load = 1'b1;
                        tmr_val  = GAP_LD;
                        state_d  = GAP;
                    end else begin
                        retry_d     = 8'd0;
                        err_d       = 1'b1;
                        err_addr_d  = rom_addr_q;
                        init_busy_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end

            GAP: begin
                if (tmr_zero) begin
                    if (!rt_mode_q) begin
                        state_d = FETCH;
                    end else if (retry_q != 8'd0) begin
                        state_d = RT_ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            RT_ISSUE: begin
                start_d     = 1'b1;
                sccb_data_d = sccb_make_word(SLAVE_ADDR, rt_reg_addr, rt_data);
                tmr_load    = 1'b1;
                tmr_val     = TIMEOUT_LD;
                state_d     = RT_WAIT;
            end

            RT_WAIT: begin
                if (sccb_done && !sccb_nack) begin
                    retry_d  = 8'd0;
                    rt_ack_d = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LD;
                    state_d  = GAP;
                end else if (sccb_done || tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LD;
                    state_d  = GAP;
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 8'd1;
                    end else begin
                        retry_d   = 8'd0;
                        rt_ack_d  = 1'b1;
                        rt_fail_d = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Single state/output register bank; every output comes straight from a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rom_addr_q  <= '0;
            err_addr_q  <= '0;
            sccb_data_q <= '0;
            retry_q     <= 8'd0;
            rt_mode_q   <= 1'b0;
            init_busy_q <= 1'b0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
            start_q     <= 1'b0;
            rt_ack_q    <= 1'b0;
            rt_fail_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            err_addr_q  <= err_addr_d;
            sccb_data_q <= sccb_data_d;
            retry_q     <= retry_d;
            rt_mode_q   <= rt_mode_d;
            init_busy_q <= init_busy_d;
            init_done_q <= init_done_d;
            err_q       <= err_d;
            start_q     <= start_d;
            rt_ack_q    <= rt_ack_d;
            rt_fail_q   <= rt_fail_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign err_addr   = err_addr_q;
    assign sccb_data  = sccb_data_q;
    assign sccb_start = start_q;
    assign init_busy  = init_busy_q;
    assign init_done  = init_done_q;
    assign err        = err_q;
    assign rt_ack     = rt_ack_q;
    assign rt_fail    = rt_fail_q;

endmodule
